// File: rtl/nn_cfg_loader.sv
// nn_cfg_loader: serial configuration-chain loader.
// Accepts a shift command (target chain + bit count), pulls 32-bit words from
// the host, shifts them LSB-first into the selected chain with a generated
// data clock, and returns the bits captured from the chain tail in 32-bit words.
// Ports:
//   clk, reset          main clock, asynchronous active-low reset
//   cmd_*               command handshake (chain index, bit length)
//   wr_*                write-word handshake (host -> chain)
//   rd_valid/rd_data    captured-word pulse (chain tail -> host)
//   cfg_data_in/clk/out per-chain serial interface
//   busy/done/err       status; done and err are one-cycle pulses
module nn_cfg_loader #(
   parameter int unsigned NUM_CHAINS  = 2,
   parameter int unsigned HALF_PERIOD = 2,
   parameter int unsigned LEN_W       = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [$clog2(NUM_CHAINS)-1:0] cmd_chain,
   input  logic [LEN_W-1:0]              cmd_len,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [31:0]                   wr_data,
   output logic                          rd_valid,
   output logic [31:0]                   rd_data,
   output logic [NUM_CHAINS-1:0]         cfg_data_in,
   output logic [NUM_CHAINS-1:0]         cfg_data_clk,
   input  logic [NUM_CHAINS-1:0]         cfg_data_out,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int unsigned CW  = $clog2(NUM_CHAINS);
   localparam int unsigned PW  = 8;
   localparam int unsigned BCW = LEN_W + 1;

   typedef enum logic [2:0] {IDLE, FETCH, LO, HI, FLUSH} state_e;

   state_e                  state_q, state_d;
   logic [PW-1:0]           phase_q, phase_d;
   logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [NUM_CHAINS-1:0]   sel_q, sel_d;
   logic [31:0]             sreg_q, sreg_d;
   logic [31:0]             rsreg_q, rsreg_d;
   logic [31:0]             rd_data_q, rd_data_d;
   logic                    rd_valid_q, rd_valid_d;
   logic                    err_q, err_d;
   logic                    done_q, busy_q, cmd_ready_q, wr_ready_q;
   logic [NUM_CHAINS-1:0]   dclk_q, din_q;

   logic [NUM_CHAINS-1:0]   cmd_sel_c;
   logic                    tail_c;
   logic                    last_phase_c;
   logic                    bad_cmd_c;

   // One-hot decode of the requested chain and out-of-range detection
   always_comb begin
      cmd_sel_c = '0;
      for (int unsigned i = 0; i < NUM_CHAINS; i++) begin
         if (cmd_chain == CW'(i)) cmd_sel_c[i] = 1'b1;
      end
      bad_cmd_c = (cmd_len == '0) || ({1'b0, cmd_chain} >= (CW + 1)'(NUM_CHAINS));
   end

   assign tail_c       = |(cfg_data_out & sel_q);
   assign last_phase_c = (phase_q == PW'(HALF_PERIOD - 1));

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_cnt_d  = bit_cnt_q;
      len_d      = len_q;
      sel_d      = sel_q;
      sreg_d     = sreg_q;
      rsreg_d    = rsreg_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               if (bad_cmd_c) begin
                  err_d = 1'b1;
               end else begin
                  sel_d     = cmd_sel_c;
                  len_d     = cmd_len;
                  bit_cnt_d = '0;
                  rsreg_d   = '0;
                  state_d   = FETCH;
               end
            end
         end
         FETCH: begin
            if (wr_valid && wr_ready_q) begin
               sreg_d  = wr_data;
               phase_d = '0;
               state_d = LO;
            end
         end
         LO: begin
            if (last_phase_c) begin
               phase_d = '0;
               state_d = HI;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         HI: begin
            // Tail sampled once, in the first cycle after the data_clk rise
            if (phase_q == '0) rsreg_d[bit_cnt_q[4:0]] = tail_c;
            if (last_phase_c) begin
               phase_d   = '0;
               bit_cnt_d = bit_cnt_q + BCW'(1);
               sreg_d    = sreg_q >> 1;
               // Emit on every word boundary and on the final bit; clearing
               // afterwards leaves the upper bits of a partial word zero
               if ((bit_cnt_d[4:0] == 5'd0) || (bit_cnt_d == {1'b0, len_q})) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = rsreg_d;
                  rsreg_d    = '0;
               end
               if (bit_cnt_d == {1'b0, len_q}) state_d = FLUSH;
               else if (bit_cnt_d[4:0] == 5'd0) state_d = FETCH;
               else state_d = LO;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         FLUSH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; outputs decode the next state so they
   // line up with the state register and cannot glitch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         bit_cnt_q   <= '0;
         len_q       <= '0;
         sel_q       <= '0;
         sreg_q      <= '0;
         rsreg_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
         wr_ready_q  <= 1'b0;
         dclk_q      <= '0;
         din_q       <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         bit_cnt_q   <= bit_cnt_d;
         len_q       <= len_d;
         sel_q       <= sel_d;
         sreg_q      <= sreg_d;
         rsreg_q     <= rsreg_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         err_q       <= err_d;
         done_q      <= (state_d == FLUSH);
         busy_q      <= (state_d != IDLE);
         cmd_ready_q <= (state_d == IDLE);
         wr_ready_q  <= (state_d == FETCH);
         dclk_q      <= (state_d == HI) ? sel_d : '0;
         din_q       <= ((state_d == LO) || (state_d == HI)) ?
                        (sel_d & {NUM_CHAINS{sreg_d[0]}}) : '0;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign wr_ready     = wr_ready_q;
   assign rd_valid     = rd_valid_q;
   assign rd_data      = rd_data_q;
   assign cfg_data_in  = din_q;
   assign cfg_data_clk = dclk_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_nn_cfg_loader.sv
// Directed bench for nn_cfg_loader: three chains, each modelled as a 4-flop
// shift chain so the tail returns the input stream delayed by 3 bits.
module tb_nn_cfg_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_chain;
   logic [15:0] cmd_len;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic [2:0]  cfg_data_in, cfg_data_clk, cfg_data_out;
   logic        busy, done, err;

   nn_cfg_loader #(.NUM_CHAINS(3), .HALF_PERIOD(2), .LEN_W(16)) dut (
      .clk(clk), .reset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_chain(cmd_chain), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .cfg_data_in(cfg_data_in), .cfg_data_clk(cfg_data_clk),
      .cfg_data_out(cfg_data_out),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int acc_cyc = 0;
   logic mon_clr = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor / chain model, sampled mid-cycle
   logic [3:0]  chain_ff [3];
   logic [63:0] cap [3];
   int          edges [3];
   int          din_hi [3];
   logic [31:0] rd_w [4];
   int          rd_cnt, err_cnt, done_cnt, busy_cnt, overlap_cnt;
   int          both_rdy_cnt = 0;
   logic [2:0]  dclk_prev = '0;

   initial begin
      for (int i = 0; i < 3; i++) begin
         chain_ff[i] = '0; cap[i] = '0; edges[i] = 0; din_hi[i] = 0;
      end
      for (int i = 0; i < 4; i++) rd_w[i] = '0;
      rd_cnt = 0; err_cnt = 0; done_cnt = 0; busy_cnt = 0; overlap_cnt = 0;
   end

   assign cfg_data_out = {chain_ff[2][3], chain_ff[1][3], chain_ff[0][3]};

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) chain_ff[i] = '0;
      end
      if (mon_clr) begin
         for (int i = 0; i < 3; i++) begin
            cap[i] = '0; edges[i] = 0; din_hi[i] = 0;
         end
         for (int i = 0; i < 4; i++) rd_w[i] = '0;
         rd_cnt = 0; err_cnt = 0; done_cnt = 0; busy_cnt = 0; overlap_cnt = 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (cfg_data_clk[i] && !dclk_prev[i]) begin
               cap[i][edges[i] % 64] = cfg_data_in[i];
               edges[i]++;
               chain_ff[i] = {chain_ff[i][2:0], cfg_data_in[i]};
            end
            if (cfg_data_in[i]) din_hi[i]++;
         end
         if (rd_valid) begin
            if (rd_cnt < 4) rd_w[rd_cnt] = rd_data;
            rd_cnt++;
         end
         if (err) err_cnt++;
         if (done) done_cnt++;
         if (busy) busy_cnt++;
         if ($countones(cfg_data_clk) > 1) overlap_cnt++;
      end
      if (cmd_ready && wr_ready) both_rdy_cnt++;
      dclk_prev = cfg_data_clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic send_cmd(input logic [1:0] ch, input logic [15:0] len);
      int n = 0;
      cmd_chain = ch;
      cmd_len   = len;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 300) begin step(); n++; end
      step();
      cmd_valid = 1'b0;
      chk("cmd_accept_in_time", 64'(n < 300), 64'(1));
   endtask

   task automatic send_word(input logic [31:0] d);
      int n = 0;
      wr_data  = d;
      wr_valid = 1'b1;
      while (!wr_ready && n < 300) begin step(); n++; end
      acc_cyc = cyc;
      step();
      wr_valid = 1'b0;
      chk("word_accept_in_time", 64'(n < 300), 64'(1));
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 600) begin step(); n++; end
      chk("done_in_time", 64'(done), 64'(1));
   endtask

   initial begin
      int bad;
      int n;
      cmd_valid = 1'b0; cmd_chain = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0;

      // Reset state
      repeat (3) step();
      chk("reset_outputs", 64'({busy, done, err, rd_valid, wr_ready, cfg_data_clk, cfg_data_in}), 64'(0));
      chk("reset_rd_data", 64'(rd_data), 64'(0));
      rst = 1'b1;
      step();
      chk("cmd_ready_first_clock", 64'(cmd_ready), 64'(1));
      chk("wr_ready_idle", 64'(wr_ready), 64'(0));

      // Single 8-bit word to chain 1
      clear_mon();
      send_cmd(2'd1, 16'd8);
      chk("A_busy_after_accept", 64'(busy), 64'(1));
      chk("A_wr_ready_fetch", 64'(wr_ready), 64'(1));
      send_word(32'h0000_00A5);
      wait_done();
      chk("A_done_latency", 64'(cyc - acc_cyc), 64'(33));
      step();
      chk("A_done_once", 64'(done_cnt), 64'(1));
      chk("A_edges_ch1", 64'(edges[1]), 64'(8));
      chk("A_edges_other", 64'(edges[0] + edges[2]), 64'(0));
      chk("A_data_ch1", 64'(cap[1][7:0]), 64'(8'hA5));
      chk("A_din_other", 64'(din_hi[0] + din_hi[2]), 64'(0));
      chk("A_rd_cnt", 64'(rd_cnt), 64'(1));
      chk("A_rd_word", 64'(rd_w[0]), 64'(32'h0000_0028));
      chk("A_busy_idle", 64'(busy), 64'(0));

      // 40 bits, second word stalled by the host
      do_reset();
      clear_mon();
      send_cmd(2'd0, 16'd40);
      send_word(32'hDEAD_BEEF);
      n = 0;
      while (!wr_ready && n < 300) begin step(); n++; end
      chk("B_reached_fetch", 64'(wr_ready), 64'(1));
      bad = 0;
      repeat (10) begin
         if (cfg_data_clk != 3'b000 || !wr_ready) bad++;
         step();
      end
      chk("B_stall_clk_low", 64'(bad), 64'(0));
      send_word(32'hFFFF_FFC3);
      wait_done();
      step();
      chk("B_edges", 64'(edges[0]), 64'(40));
      chk("B_stream", 64'(cap[0][39:0]), 64'({8'hC3, 32'hDEAD_BEEF}));
      chk("B_rd_cnt", 64'(rd_cnt), 64'(2));
      chk("B_rd_word0", 64'(rd_w[0]), 64'(32'hF56D_F778));
      chk("B_rd_word1", 64'(rd_w[1]), 64'(32'h0000_001E));

      // 64-bit loopback on chain 2
      do_reset();
      clear_mon();
      send_cmd(2'd2, 16'd64);
      send_word(32'h1234_5678);
      send_word(32'h9ABC_DEF0);
      wait_done();
      step();
      chk("C_edges", 64'(edges[2]), 64'(64));
      chk("C_rd_cnt", 64'(rd_cnt), 64'(2));
      chk("C_rd_word0", 64'(rd_w[0]), 64'(32'h91A2_B3C0));
      chk("C_rd_word1", 64'(rd_w[1]), 64'(32'hD5E6_F780));

      // Rejected commands
      clear_mon();
      send_cmd(2'd0, 16'd0);
      chk("D_err_len0", 64'({err, busy, cmd_ready}), 64'(3'b101));
      send_cmd(2'd3, 16'd5);
      chk("D_err_chain", 64'({err, busy, cmd_ready}), 64'(3'b101));
      step();
      chk("D_err_single_pulse", 64'(err), 64'(0));
      step();
      chk("D_err_cnt", 64'(err_cnt), 64'(2));
      chk("D_no_edges", 64'(edges[0] + edges[1] + edges[2]), 64'(0));
      chk("D_busy_never", 64'(busy_cnt), 64'(0));

      // Reset during the high phase of bit 5
      do_reset();
      clear_mon();
      send_cmd(2'd1, 16'd16);
      send_word(32'h0000_FFFF);
      n = 0;
      while (edges[1] < 6 && n < 300) begin step(); n++; end
      chk("E_reached_bit5", 64'(edges[1]), 64'(6));
      chk("E_clk_high", 64'(cfg_data_clk), 64'(3'b010));
      rst = 1'b0;
      #1;
      chk("E_async_reset", 64'({busy, done, err, rd_valid, wr_ready, cmd_ready, cfg_data_clk, cfg_data_in}), 64'(0));
      step();
      step();
      rst = 1'b1;
      step();
      chk("E_ready_after_release", 64'(cmd_ready), 64'(1));
      clear_mon();
      send_cmd(2'd0, 16'd8);
      send_word(32'h0000_00A5);
      wait_done();
      step();
      chk("E_edges", 64'(edges[0]), 64'(8));
      chk("E_data", 64'(cap[0][7:0]), 64'(8'hA5));
      chk("E_rd_word", 64'(rd_w[0]), 64'(32'h0000_0028));
      chk("E_ch1_quiet", 64'(edges[1]), 64'(0));

      // Back-to-back commands, chain 0 then chain 1
      clear_mon();
      send_cmd(2'd0, 16'd4);
      send_word(32'h0000_0005);
      wait_done();
      chk("F_ready_low_at_done", 64'(cmd_ready), 64'(0));
      step();
      chk("F_ready_after_done", 64'(cmd_ready), 64'(1));
      send_cmd(2'd1, 16'd4);
      send_word(32'h0000_000A);
      wait_done();
      step();
      chk("F_edges", 64'({edges[0][7:0], edges[1][7:0]}), 64'(16'h0404));
      chk("F_data", 64'({cap[0][3:0], cap[1][3:0]}), 64'(8'h5A));
      chk("F_no_overlap", 64'(overlap_cnt), 64'(0));
      chk("F_rd_cnt", 64'(rd_cnt), 64'(2));
      chk("ready_exclusive", 64'(both_rdy_cnt), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
